// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encodings and default operand width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of A - B - Bin.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock through a single full subtractor.
// State table: IDLE | waiting for start ; RUN | shifting one bit per cycle ; DONE | result valid, one-cycle done pulse
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept   = start && (r_state != RUN);
  assign w_last     = (r_cnt == LAST);
  assign w_res_next = WIDTH'({w_d, r_res} >> 1);

  full_subtractor u_fs (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_br),
    .D    (w_d),
    .Bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // On the final bit the operand MSBs sit at r_a[0]/r_b[0], so overflow uses them directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_res <= '0;
      r_cnt <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_br  <= Bin;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_bout;
      r_res <= w_res_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        Diff <= w_res_next;
        Bout <= w_bout;
        Ovf  <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus random operations vs. an arithmetic model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Ovf;

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, bout, diff[3:0]} from plain integer arithmetic.
  function automatic logic [5:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int         full;
    logic [3:0] d;
    logic       bo;
    logic       ov;
    full = int'(a) - int'(b) - int'(bin);
    d    = 4'(full & 15);
    bo   = (full < 0);
    ov   = (a[3] != b[3]) && (d[3] != a[3]);
    return {ov, bo, d};
  endfunction

  task automatic check_result(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [5:0] r;
    r = ref_sub(a, b, bin);
    check({tag, "_diff"}, 32'(Diff), 32'(r[3:0]));
    check({tag, "_bout"}, 32'(Bout), 32'(r[4]));
    check({tag, "_ovf"},  32'(Ovf),  32'(r[5]));
  endtask

  // Launches one operation and returns just after done is seen (still in the done cycle).
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin);
    int k;
    bit got;
    @(negedge clk);
    start = 1'b1; A = a; B = b; Bin = bin;
    @(posedge clk); #1;
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom); Bin = 1'($urandom);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_done0"}, 32'(done), 32'd0);
    k = 0; got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (done) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(k), 32'(WIDTH));
    check({tag, "_busyd"}, 32'(busy), 32'd0);
    check_result(tag, a, b, bin);
  endtask

  task automatic go_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [3:0] dsave;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(Diff), 32'd0);
    check("rst_bout", 32'(Bout), 32'd0);
    check("rst_ovf",  32'(Ovf),  32'd0);
    rst = 1'b0;

    do_op("d7m3", 4'd7, 4'd3, 1'b0); go_idle("d7m3");
    check("d7m3_hold", 32'(Diff), 32'd4);
    do_op("d3m7", 4'd3, 4'd7, 1'b0); go_idle("d3m7");
    do_op("d8m1", 4'd8, 4'd1, 1'b0); go_idle("d8m1");
    do_op("d0m0b", 4'd0, 4'd0, 1'b1); go_idle("d0m0b");

    // Second start while busy must be ignored entirely.
    @(negedge clk);
    start = 1'b1; A = 4'd5; B = 4'd2; Bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; dsave = '0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 3) begin start = 1'b1; A = 4'd1; B = 4'd1; end
      if (c == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; dsave = Diff; end
    end
    check("busy_ign_ndone", 32'(ndone), 32'd1);
    check("busy_ign_diff",  32'(dsave), 32'd3);

    // Reset two cycles into RUN aborts with no done.
    @(negedge clk);
    start = 1'b1; A = 4'd9; B = 4'd2; Bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(Diff), 32'd0);
    check("abort_bout", 32'(Bout), 32'd0);
    check("abort_ovf",  32'(Ovf),  32'd0);
    ndone = 0;
    repeat (8) begin @(posedge clk); #1; if (done) ndone++; end
    check("abort_nodone", 32'(ndone), 32'd0);
    do_op("d6m6", 4'd6, 4'd6, 1'b0); go_idle("d6m6");

    // Reset has priority over start.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; A = 4'd3; B = 4'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);

    // Random operations, some launched back-to-back from the done cycle.
    for (int i = 0; i < 40; i++) begin
      do_op("rnd", 4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) go_idle("rnd");
    end
    go_idle("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
